// File: rtl/mac_result_accum_pkg.sv
// Shared constants and types for the MAC result accumulator.
// S is the operand width of the upstream MAC.
package mac_result_accum_pkg;

  localparam int S       = 8;
  localparam int N_TERMS = 4;
  localparam int ACC_W   = 2*S + $clog2(N_TERMS);
  localparam int CNT_W   = $clog2(N_TERMS) + 1;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} accum_state_t;

  function automatic logic [ACC_W-1:0] zext_term(input logic [2*S-1:0] d);
    return {{(ACC_W-2*S){1'b0}}, d};
  endfunction

endpackage

// File: rtl/mac_result_accum_if.sv
// Handshake bundle between the MAC result source, the accumulator and its consumer.
interface mac_result_accum_if
  import mac_result_accum_pkg::*;
  ();

  logic             start;
  logic             in_valid;
  logic [2*S-1:0]   in_data;
  logic             in_ready;
  logic             out_valid;
  logic [ACC_W-1:0] out_data;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] term_cnt;

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, term_cnt
  );

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, term_cnt
  );

endinterface

// File: rtl/mac_result_accum.sv
// Sums groups of N_TERMS MAC results and offers each total on a valid/ready port.
// All handshake outputs decode from registered state only.
module mac_result_accum
  import mac_result_accum_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  mac_result_accum_if.slave bus
);

  accum_state_t     state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] sum;
  logic             accept;

  assign accept = bus.in_valid && (state_q == ACC);
  assign sum    = acc_q + zext_term(bus.in_data);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ACC: begin
        if (accept) begin
          if (cnt_q == CNT_W'(N_TERMS-1)) begin
            // Final word goes straight to the output register.
            out_data_d = sum;
            cnt_d      = CNT_W'(N_TERMS);
            state_d    = HOLD;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          cnt_d = '0;
          if (bus.start) begin
            state_d = ACC;
            acc_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.term_cnt  = cnt_q;

endmodule

// File: tb/tb_mac_result_accum.sv
// Directed and randomized bench for mac_result_accum; group totals come from
// plain integer sums of the words the bench chose to send.
module tb_mac_result_accum;
  import mac_result_accum_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [2*S-1:0] wq[$];
  int             gq[$];
  bit             in_acc;

  mac_result_accum_if ifc ();

  mac_result_accum dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_group();
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    chk("start_rdy",  32'(ifc.in_ready), 32'd1);
    chk("start_busy", 32'(ifc.busy), 32'd1);
    chk("start_cnt",  32'(ifc.term_cnt), 32'd0);
    chk("start_vld",  32'(ifc.out_valid), 32'd0);
  endtask

  // Sends wq with gq[i] idle cycles before word i, stalls the output, then takes it.
  task automatic feed_group(input int stall, input bit chain);
    int exp_sum;
    exp_sum = 0;
    for (int i = 0; i < wq.size(); i++) begin
      for (int g = 0; g < gq[i]; g++) begin
        ifc.in_valid = 1'b0;
        ifc.in_data  = (2*S)'($urandom);
        step();
        chk("gap_cnt", 32'(ifc.term_cnt), 32'(i));
        chk("gap_rdy", 32'(ifc.in_ready), 32'd1);
      end
      ifc.in_valid = 1'b1;
      ifc.in_data  = wq[i];
      exp_sum += int'(wq[i]);
      step();
      ifc.in_valid = 1'b0;
      if (i < N_TERMS-1) chk("acc_cnt", 32'(ifc.term_cnt), 32'(i+1));
    end
    chk("done_vld",  32'(ifc.out_valid), 32'd1);
    chk("done_data", 32'(ifc.out_data), 32'(exp_sum));
    chk("done_cnt",  32'(ifc.term_cnt), 32'(N_TERMS));
    chk("done_rdy",  32'(ifc.in_ready), 32'd0);
    ifc.out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      ifc.in_valid = 1'($urandom_range(0, 1));
      ifc.in_data  = (2*S)'($urandom);
      ifc.start    = 1'($urandom_range(0, 1));
      step();
      chk("hold_vld",  32'(ifc.out_valid), 32'd1);
      chk("hold_data", 32'(ifc.out_data), 32'(exp_sum));
      chk("hold_rdy",  32'(ifc.in_ready), 32'd0);
      chk("hold_cnt",  32'(ifc.term_cnt), 32'(N_TERMS));
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    ifc.start     = chain;
    step();
    ifc.out_ready = 1'b0;
    ifc.start     = 1'b0;
    chk("xfer_vld",  32'(ifc.out_valid), 32'd0);
    chk("xfer_cnt",  32'(ifc.term_cnt), 32'd0);
    chk("xfer_data", 32'(ifc.out_data), 32'(exp_sum));
    chk("xfer_busy", 32'(ifc.busy), 32'(chain));
    chk("xfer_rdy",  32'(ifc.in_ready), 32'(chain));
  endtask

  initial begin
    ifc.start     = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b0;
    reset         = 1'b1;
    #12;
    chk("rst_vld",  32'(ifc.out_valid), 32'd0);
    chk("rst_rdy",  32'(ifc.in_ready), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_cnt",  32'(ifc.term_cnt), 32'd0);
    chk("rst_data", 32'(ifc.out_data), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Reset mid-group discards the partial sum
    start_group();
    for (int i = 0; i < 2; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = 16'h0005;
      step();
    end
    ifc.in_valid = 1'b0;
    chk("mid_cnt", 32'(ifc.term_cnt), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("arst_cnt",  32'(ifc.term_cnt), 32'd0);
    chk("arst_vld",  32'(ifc.out_valid), 32'd0);
    chk("arst_busy", 32'(ifc.busy), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_rdy", 32'(ifc.in_ready), 32'd0);
    wq = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
    gq = '{0, 0, 0, 0};
    start_group();
    feed_group(0, 1'b0);

    // Basic group
    wq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    start_group();
    feed_group(0, 1'b0);

    // Maximum values
    wq = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    start_group();
    feed_group(0, 1'b0);

    // Input gaps
    wq = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    gq = '{0, 2, 0, 1};
    start_group();
    feed_group(0, 1'b0);

    // Output stall
    wq = '{16'h1234, 16'h0F0F, 16'h00AA, 16'h7001};
    gq = '{0, 0, 0, 0};
    start_group();
    feed_group(5, 1'b0);

    // IDLE words are not counted, then back-to-back groups
    ifc.in_valid = 1'b1;
    ifc.in_data  = 16'h7777;
    step();
    ifc.in_valid = 1'b0;
    chk("idle_cnt", 32'(ifc.term_cnt), 32'd0);
    chk("idle_rdy", 32'(ifc.in_ready), 32'd0);
    wq = '{16'h0020, 16'h0030, 16'h0040, 16'h0050};
    start_group();
    feed_group(1, 1'b1);
    wq = '{16'h0010, 16'h0010, 16'h0010, 16'h0010};
    feed_group(0, 1'b0);

    // Randomized groups
    in_acc = 1'b0;
    for (int r = 0; r < 12; r++) begin
      wq.delete();
      gq.delete();
      for (int k = 0; k < N_TERMS; k++) begin
        wq.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : (2*S)'($urandom));
        gq.push_back(int'($urandom_range(0, 2)));
      end
      if (!in_acc) start_group();
      in_acc = 1'($urandom_range(0, 1));
      feed_group(int'($urandom_range(0, 3)), in_acc);
    end
    if (in_acc) begin
      wq = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
      gq = '{0, 0, 0, 0};
      feed_group(0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_result_accum.md
Name: mac_result_accum

Overview:
Downstream stage of the multiply-accumulate block: consumes its registered 2*S-bit product-plus-addend results and sums a fixed-length group of N_TERMS of them into one wider total. Each sum is offered on a valid/ready output handshake, so a slower consumer can stall the block. Used for dot-product / FIR-tap style reductions built from the per-cycle MAC.

Parameters:
S, 8 (taken from the shared package constant), operand width of the upstream MAC; input word is 2*S bits
N_TERMS, 4, number of input words summed per group; legal range 2..256
ACC_W, 2*S+$clog2(N_TERMS), accumulator/output width; derived, never overridden

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin a new group; sampled only in IDLE, or in HOLD on the cycle the output is taken
in_valid  in  1  in_data carries a valid MAC result this cycle
in_data  in  2*S  unsigned MAC result
in_ready  out  1  block accepts in_data this cycle
out_valid  out  1  out_data holds a completed group sum
out_data  out  ACC_W  unsigned sum of N_TERMS accepted words
out_ready  in  1  consumer accepts out_data
busy  out  1  high in ACC or HOLD
term_cnt  out  $clog2(N_TERMS)+1  words accepted in the current group

Behaviour:
- Reset is asynchronous and active-high: state=IDLE, acc=0, term_cnt=0, out_data=0, out_valid=0, in_ready=0, busy=0.
- States: IDLE, ACC, HOLD. in_ready, out_valid and busy are decoded from the registered state only; no combinational path from any input to any output.
- In_ready=1 only in ACC. Out_valid=1 only in HOLD.
- IDLE:
  - start=1 -> ACC; acc and term_cnt cleared on the same edge.
  - in_valid in IDLE is ignored; no data is accepted.
- ACC:
  - Accept = in_valid & in_ready. On accept, acc <= acc + zero-extended in_data and term_cnt increments.
  - No accept (in_valid=0) -> hold acc and term_cnt; gaps of any length are allowed.
  - Accept while term_cnt==N_TERMS-1 -> out_data <= acc + in_data, term_cnt <= N_TERMS, state -> HOLD.
  - Out_valid rises on the edge after the last accepted word (1-cycle latency from final accept).
  - start is ignored in ACC.
- HOLD:
  - out_data and out_valid are held stable until out_ready=1.
  - out_valid & out_ready -> transfer complete.
  - If start=1 on that same cycle -> ACC with acc and term_cnt cleared, giving back-to-back groups with one cycle of in_ready=0.
  - Otherwise -> IDLE, term_cnt cleared.
  - out_data keeps its last value after the transfer, until the next group completes or reset.
- Width rules: ACC_W bits cannot overflow (N_TERMS*(2^(2S)-1) < 2^ACC_W); no saturation logic. All arithmetic is unsigned.
- Reset asserted mid-group discards the partial sum; the block is in IDLE on the first clock after reset releases.

Decomposition:
- Shared package (the one already exporting S) gains:
  - N_TERMS default constant
  - ACC_W derivation
  - typedef enum logic [1:0] {IDLE, ACC, HOLD} accum_state_t
- No sub-module is needed. The state register, accumulator and counter fit in one module; a separate counter module adds nothing.

Test Plan:
- Reset mid-group: reset pulse after 2 of 4 words -> out_valid=0, term_cnt=0 immediately; next start plus 4 words of 0x0001 -> out_data=0x00004.
- Basic group: start, then 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles with out_ready=1 -> out_valid high for 1 cycle, out_data=0x0000A, then IDLE.
- Maximum values: four words of 0xFFFF -> out_data=0x3FFFC (ACC_W=18), with no wrap.
- Input gaps: words 0x0100, gap, gap, 0x0200, 0x0300, gap, 0x0400 -> out_data=0x00A00, and term_cnt advances only on accepts.
- Output stall: out_ready=0 for 5 cycles after completion -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> single transfer.
- Back-to-back groups: start held high through the HOLD transfer -> ACC next cycle, second group of 0x0010 x4 -> out_data=0x00040; the IDLE-state in_valid=1 with start=0 word is never counted.
